ksa16_pipe: RTL
===============

# ksa16_pipe

Pipelined, flow-controlled Kogge-Stone adder: the datapath responder that accepts operand pairs over a valid/ready interface and returns `{cout, sum}` = A + B + Cin several cycles later. It is the registered, streaming counterpart of the combinational 16-bit Kogge-Stone adder, for use where operand producers and result consumers are clocked and may stall. It sits between an operand source (e.g. a DMA or ALU issue stage) and a result sink, and preserves ordering.

## Interface
- `WIDTH`, 16, operand width; power of two, minimum 4.
- `TAG_W`, 4, width of the opaque sideband tag carried alongside each operation.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept this cycle.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_cin`  in  1  carry in.
- `in_tag`  in  TAG_W  sideband tag, returned unchanged.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  sink accepts result.
- `out_sum`  out  WIDTH  (A+B+Cin) mod 2^WIDTH.
- `out_cout`  out  1  carry out, bit WIDTH of A+B+Cin.
- `out_tag`  out  TAG_W  tag of this result.

## Operation
- LEVELS = log2(WIDTH); 4 for WIDTH=16. Pipeline has S = LEVELS+1 register stages.
- Stage 1 (pre-process): p[i]=a[i]^b[i], g[i]=a[i]&b[i]; Cin folded into bit 0: g[0]=a[0]&b[0] | p[0]&cin. Register p (kept for sum), g, p, cin, tag.
- Stages 2..S (prefix level k=0..LEVELS-1, distance d=2^k): for i>=d, G[i]=G[i]|P[i]&G[i-d], P[i]=P[i]&P[i-d]; for i<d pass through. Original p, cin, tag travel unchanged.
- Output (combinational from stage S): c[0]=cin, c[i]=G[i-1]; out_sum[i]=p[i]^c[i]; out_cout=G[WIDTH-1].
- Flow control, bubble-collapsing: stage k loads when !v[k] or stage k+1 loads; last stage "advances" when !v[S] or out_ready. in_ready = stage-1 load enable. Transfer occurs on in_valid&in_ready / out_valid&out_ready.
- Stage with no incoming valid and enable set loads v=0 (bubble); data registers need not update on bubbles.
- Strict in-order, no drop, no duplication. Capacity exactly S operations.
- No FSM beyond per-stage valid bits.

## Timing
- Latency: accepted at edge t -> out_valid high after edge t+S (5 cycles for WIDTH=16), given no stalls.
- Throughput: one result per cycle while out_ready=1.
- out_valid/out_sum/out_cout/out_tag hold stable while out_valid&!out_ready.
- in_ready may depend combinationally on out_ready (ready chain); no combinational path from in_* data to out_*.
- Full: all S stages valid and out_ready=0 -> in_ready=0. Simultaneous accept and emit when full with out_ready=1 -> allowed; occupancy unchanged.
- Reset: after the rst edge all valid bits 0, out_valid=0, out_sum=0, out_cout=0, out_tag=0, in_ready=1 the cycle after rst deasserts (rst has priority over any transfer that cycle). Reset mid-operation discards all in-flight operations; none appear at output.
- Wrap: sum is modulo 2^WIDTH; overflow reported only via out_cout.

## Structure
- Shared package `ksa_pkg`: WIDTH default, LEVELS (clog2), stage-record type {v, g, P, p, cin, tag}.
- One natural sub-module `ksa_prefix_level` (parameter DIST): one registered Kogge-Stone level with load enable and valid; instantiated LEVELS times by generate.
- Pre-process and output sum logic live in the top.

## Test plan
- Reset: rst=1 two cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=1 after release, nothing emitted.
- Single op A=FFFF, B=0001, cin=0, tag=3 -> 5 cycles later out_sum=0000, out_cout=1, out_tag=3, one cycle only.
- Stream with out_ready=1: 1234+4321+1 -> 5556/0; 8000+8000+0 -> 0000/1; FFFF+FFFF+1 -> FFFF/1; back-to-back results on consecutive cycles, order preserved.
- Backpressure: out_ready=0, stream ops -> exactly 5 accepted then in_ready=0, outputs stable; out_ready=1 -> 5 results drain in order, no loss or duplication.
- Reset mid-flight: 3 ops accepted, rst for 1 cycle -> out_valid=0 next cycle, none of the 3 emerge later.
- Random/exhaustive: all 65536 A values x random B/cin with random out_ready stalls, scoreboard vs A+B+cin -> zero mismatches.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared defaults for the pipelined Kogge-Stone adder: widths, prefix depth, stage record.
package ksa_pkg;
   localparam int KSA_WIDTH  = 16;
   localparam int KSA_TAG_W  = 4;
   localparam int KSA_LEVELS = $clog2(KSA_WIDTH);

   // One pipeline stage at the default widths: group generate/propagate plus the
   // original bit-propagate, carry-in and tag that ride along to the output.
   typedef struct packed {
      logic                 v;
      logic [KSA_WIDTH-1:0] g;
      logic [KSA_WIDTH-1:0] gp;
      logic [KSA_WIDTH-1:0] p;
      logic                 cin;
      logic [KSA_TAG_W-1:0] tag;
   } stage_t;
endpackage

// File: rtl/ksa_prefix_level.sv
// One registered Kogge-Stone prefix level combining bit i with bit i-DIST.
// Latency 1 cycle; loads only when en is high, otherwise holds (stall).
// A bubble (in_v=0) clears the valid bit and leaves the data registers alone.
module ksa_prefix_level #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4,
   parameter int DIST  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_v,
   input  logic [WIDTH-1:0] in_g,
   input  logic [WIDTH-1:0] in_gp,
   input  logic [WIDTH-1:0] in_p,
   input  logic             in_cin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_v,
   output logic [WIDTH-1:0] out_g,
   output logic [WIDTH-1:0] out_gp,
   output logic [WIDTH-1:0] out_p,
   output logic             out_cin,
   output logic [TAG_W-1:0] out_tag
);
   logic [WIDTH-1:0] g_nxt;
   logic [WIDTH-1:0] gp_nxt;

   always_comb begin
      g_nxt  = in_g;
      gp_nxt = in_gp;
      for (int i = DIST; i < WIDTH; i++) begin
         g_nxt[i]  = in_g[i] | (in_gp[i] & in_g[i-DIST]);
         gp_nxt[i] = in_gp[i] & in_gp[i-DIST];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_v   <= 1'b0;
         out_g   <= '0;
         out_gp  <= '0;
         out_p   <= '0;
         out_cin <= 1'b0;
         out_tag <= '0;
      end else if (en) begin
         out_v <= in_v;
         if (in_v) begin
            out_g   <= g_nxt;
            out_gp  <= gp_nxt;
            out_p   <= in_p;
            out_cin <= in_cin;
            out_tag <= in_tag;
         end
      end
   end
endmodule

// File: rtl/ksa16_pipe.sv
// Streaming Kogge-Stone adder returning {cout, sum} = a + b + cin with its tag, in order.
// Latency LEVELS+1 register stages; one result per cycle when the sink is ready.
// Bubble-collapsing valid/ready: a stage loads if it or any stage after it is empty or out_ready.
module ksa16_pipe
   import ksa_pkg::*;
#(
   parameter int WIDTH = KSA_WIDTH,
   parameter int TAG_W = KSA_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic [TAG_W-1:0] out_tag
);
   localparam int LEVELS = $clog2(WIDTH);

   logic             s0_v;
   logic [WIDTH-1:0] s0_g;
   logic [WIDTH-1:0] s0_gp;
   logic [WIDTH-1:0] s0_p;
   logic             s0_cin;
   logic [TAG_W-1:0] s0_tag;

   wire  [LEVELS:0]  v;
   wire  [WIDTH-1:0] g   [LEVELS+1];
   wire  [WIDTH-1:0] gp  [LEVELS+1];
   wire  [WIDTH-1:0] p   [LEVELS+1];
   wire  [LEVELS:0]  cin;
   wire  [TAG_W-1:0] tag [LEVELS+1];

   logic [LEVELS:0]  en;
   logic             full_tail;

   // Unrolled ready chain: stage s may load unless s..last are all full and the sink stalls.
   always_comb begin
      full_tail = 1'b1;
      en        = '0;
      for (int s = LEVELS; s >= 0; s--) begin
         full_tail = full_tail & v[s];
         en[s]     = out_ready | ~full_tail;
      end
   end

   assign in_ready = en[0];

   // Carry-in is folded into bit 0's generate so the prefix tree needs no special case.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_v   <= 1'b0;
         s0_g   <= '0;
         s0_gp  <= '0;
         s0_p   <= '0;
         s0_cin <= 1'b0;
         s0_tag <= '0;
      end else if (en[0]) begin
         s0_v <= in_valid;
         if (in_valid) begin
            s0_g   <= (in_a & in_b) | {{(WIDTH-1){1'b0}}, (in_a[0] ^ in_b[0]) & in_cin};
            s0_gp  <= in_a ^ in_b;
            s0_p   <= in_a ^ in_b;
            s0_cin <= in_cin;
            s0_tag <= in_tag;
         end
      end
   end

   assign v[0]   = s0_v;
   assign g[0]   = s0_g;
   assign gp[0]  = s0_gp;
   assign p[0]   = s0_p;
   assign cin[0] = s0_cin;
   assign tag[0] = s0_tag;

   for (genvar l = 0; l < LEVELS; l++) begin : g_level
      ksa_prefix_level #(
         .WIDTH (WIDTH),
         .TAG_W (TAG_W),
         .DIST  (1 << l)
      ) u_level (
         .clk     (clk),
         .rst     (rst),
         .en      (en[l+1]),
         .in_v    (v[l]),
         .in_g    (g[l]),
         .in_gp   (gp[l]),
         .in_p    (p[l]),
         .in_cin  (cin[l]),
         .in_tag  (tag[l]),
         .out_v   (v[l+1]),
         .out_g   (g[l+1]),
         .out_gp  (gp[l+1]),
         .out_p   (p[l+1]),
         .out_cin (cin[l+1]),
         .out_tag (tag[l+1])
      );
   end

   assign out_valid = v[LEVELS];
   assign out_sum   = p[LEVELS] ^ {g[LEVELS][WIDTH-2:0], cin[LEVELS]};
   assign out_cout  = g[LEVELS][WIDTH-1];
   assign out_tag   = tag[LEVELS];
endmodule
